mul_seq: RTL
============

Name: mul_seq

Overview:
- Multi-cycle sequencer that computes the low WIDTH bits of an unsigned product A*B by iterative shift-add.
- It drives the shared ALU (add opcode only) once per cycle instead of instantiating its own adder.
- It sits beside the ALU in the execute stage.
- Operands arrive over a valid/ready request interface; the result leaves over a valid/ready response interface.
- While running, it raises alu_req so the external ALU operand mux selects the sequencer.

Parameters:
- WIDTH, 32, operand/result width; must match ALU width.
- CNT_W, $clog2(WIDTH), iteration counter width.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  request operands valid.
- in_ready  output  1  sequencer can accept a request.
- op_a  input  WIDTH  multiplicand.
- op_b  input  WIDTH  multiplier.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- result  output  WIDTH  low WIDTH bits of op_a*op_b.
- alu_req  output  1  sequencer owns the ALU this cycle.
- alu_op1  output  WIDTH  ALU operand 1.
- alu_op2  output  WIDTH  ALU operand 2.
- alu_ctrl  output  3  ALU opcode.
- alu_out  input  WIDTH  ALU result, combinational, same cycle.

Behaviour:
- Single clock domain. Reset is asynchronous, active-low.
- Reset values: state=IDLE, acc=0, mcand=0, mplier=0, cnt=0. Outputs in_ready=1, out_valid=0, result=0, alu_req=0, alu_op1=0, alu_op2=0, alu_ctrl=3'b000.
- States: IDLE, RUN, DONE, held in a 2-bit enum.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready at a clock edge: mcand<=op_a, mplier<=op_b, acc<=0, cnt<=0, go to RUN.
- RUN:
  - in_ready=0, alu_req=1, alu_ctrl=ALU_ADD (3'b000), alu_op1=acc.
  - alu_op2 = mplier[0] ? mcand : 0.
  - Each edge: acc<=alu_out, mcand<=mcand<<1, mplier<=mplier>>1, cnt<=cnt+1.
  - Go to DONE after the iteration with cnt==WIDTH-1.
  - Exactly WIDTH iterations are performed.
- DONE:
  - out_valid=1, alu_req=0, in_ready=0.
  - On out_ready at an edge: go to IDLE.
  - Same-cycle acceptance of a new request is not supported; back-to-back throughput is one product per WIDTH+2 cycles.
- result is driven from acc in every state.
  - Stable and held while out_valid=1 && out_ready=0.
  - Not meaningful outside DONE.
- Latency: out_valid rises WIDTH clock edges after the accepting edge.
- Arithmetic:
  - Unsigned, modulo 2^WIDTH; overflow bits are discarded.
  - Signed operands give correct low bits (two's complement).
- alu_op1/alu_op2/alu_ctrl are 0 whenever alu_req=0, so an idle sequencer never disturbs the shared mux.
- Boundary conditions:
  - in_valid during RUN/DONE is ignored; the requester must hold it until in_ready.
  - op_a=0 or op_b=0 gives result 0.
  - Reset asserted mid-RUN or in DONE returns to IDLE immediately (asynchronously) with all registers cleared; the partial product is discarded and out_valid drops.
  - out_ready while not in DONE has no effect.

Optional Feature:
- Macro MUL_SEQ_EARLY_TERM_EN.
- Defined:
  - In RUN, go to DONE after the iteration in which (mplier>>1)==0, or when cnt==WIDTH-1, whichever comes first.
  - Iterations = max(1, index of highest set bit of op_b + 1).
  - out_valid rises that many edges after acceptance.
- Undefined: fixed WIDTH iterations, as specified above.
- The result value is identical in both builds.

Decomposition:
- Shared package alu_pkg holds:
  - ALU opcode constants ALU_ADD=3'b000, ALU_SUB=3'b001, ALU_AND=3'b010, ALU_OR=3'b011.
  - typedef enum logic [1:0] mul_state_t {IDLE, RUN, DONE}.
- The ALU stays external; no sub-module is instantiated.
- The bench instantiates the existing ALU and connects alu_op1/alu_op2/alu_ctrl to it, with alu_out fed back.

Test Plan:
- Basic product: op_a=7, op_b=6, out_ready=1.
  - result=42.
  - out_valid 32 edges after accept (3 with MUL_SEQ_EARLY_TERM_EN).
  - alu_req high exactly during RUN.
- Wrap-around: op_a=0xFFFFFFFF, op_b=0xFFFFFFFF.
  - result=0x00000001.
  - Also op_a=0x80000000, op_b=2 gives result=0.
- Zero operands:
  - op_b=0 gives result=0, with 1 iteration under EARLY_TERM.
  - op_a=0, op_b=0xFFFFFFFF gives result=0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE.
  - out_valid and result (e.g. 12345*678=8369910) stay stable.
  - in_ready=0 throughout.
  - IDLE is reached one edge after out_ready=1.
- Ignored request: assert in_valid with op_a=3, op_b=3 during RUN of 5*5.
  - result=25.
  - The second request is accepted only once back in IDLE and yields 9.
- Mid-operation reset: drop rst_n for 1 cycle at iteration 10 of 0x1234*0x5678.
  - All outputs go to reset values immediately.
  - A subsequent 2*3 gives 6.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: ALU opcodes and multiply sequencer state encoding shared by execute-stage blocks
package alu_pkg;
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  typedef enum logic [1:0] {IDLE, RUN, DONE} mul_state_t;
endpackage

// File: rtl/mul_seq.sv
// mul_seq: shift-add multiplier borrowing the shared ALU adder; MUL_SEQ_EARLY_TERM_EN stops once the multiplier is exhausted
module mul_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             alu_req,
  output logic [WIDTH-1:0] alu_op1,
  output logic [WIDTH-1:0] alu_op2,
  output logic [2:0]       alu_ctrl,
  input  logic [WIDTH-1:0] alu_out
);
  mul_state_t state, state_nxt;
  logic [WIDTH-1:0] acc, mcand, mplier;
  logic [CNT_W-1:0] cnt;
  logic last;

`ifdef MUL_SEQ_EARLY_TERM_EN
  assign last = (cnt == CNT_W'(WIDTH - 1)) || (mplier[WIDTH-1:1] == '0);
`else
  assign last = (cnt == CNT_W'(WIDTH - 1));
`endif

  assign result = acc;

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // next state and handshake/ALU outputs; ALU operands stay zero unless the sequencer owns the mux
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    alu_req   = 1'b0;
    alu_op1   = '0;
    alu_op2   = '0;
    alu_ctrl  = ALU_ADD;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = RUN;
      end
      RUN: begin
        alu_req = 1'b1;
        alu_op1 = acc;
        alu_op2 = mplier[0] ? mcand : '0;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // operand capture on accept, then one shift-add step per RUN cycle using the ALU sum
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
    end else if (state == IDLE && in_valid) begin
      acc    <= '0;
      mcand  <= op_a;
      mplier <= op_b;
      cnt    <= '0;
    end else if (state == RUN) begin
      acc    <= alu_out;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
    end
  end
endmodule
